// File: rtl/c1541_sd_arbiter.sv
// Round-robin arbiter sharing one hps_io SD block channel among NDRIVES c1541_sd
// instances; a grant covers a whole block and lasts until the host ack falls.
module c1541_sd_arbiter #(
   parameter int unsigned NDRIVES = 4
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   input  logic [32*NDRIVES-1:0] drv_lba,
   input  logic [NDRIVES-1:0]    drv_rd,
   input  logic [NDRIVES-1:0]    drv_wr,
   output logic [NDRIVES-1:0]    drv_ack,
   output logic [NDRIVES-1:0]    drv_buff_wr,
   input  logic [8*NDRIVES-1:0]  drv_buff_din,
   output logic [31:0]           sd_lba,
   output logic                  sd_rd,
   output logic                  sd_wr,
   input  logic                  sd_ack,
   input  logic                  sd_buff_wr,
   output logic [7:0]            sd_buff_din,
   output logic [1:0]            grant,
   output logic                  busy
);
   localparam int unsigned IW    = 2;
   localparam int unsigned LBA_W = 32;
   localparam int unsigned DAT_W = 8;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_REL} state_e;

   state_e           state_q, state_d;
   logic [IW-1:0]    grant_q, grant_d;
   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [LBA_W-1:0] lba_q, lba_d;
   logic             rd_q, rd_d;
   logic             wr_q, wr_d;

   logic [NDRIVES-1:0] req;
   logic [LBA_W-1:0]   lba_arr [NDRIVES];
   logic [DAT_W-1:0]   din_arr [NDRIVES];
   logic               pick_vld;
   logic [IW-1:0]      pick_idx;

   assign req = drv_rd | drv_wr;

   for (genvar g = 0; g < NDRIVES; g++) begin : g_unpack
      assign lba_arr[g] = drv_lba[LBA_W*g +: LBA_W];
      assign din_arr[g] = drv_buff_din[DAT_W*g +: DAT_W];
   end

   // First requester at or after rr_ptr, wrapping modulo NDRIVES.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int k = 0; k < int'(NDRIVES); k++) begin
         if (!pick_vld && req[IW'((int'(rr_ptr_q) + k) % int'(NDRIVES))]) begin
            pick_vld = 1'b1;
            pick_idx = IW'((int'(rr_ptr_q) + k) % int'(NDRIVES));
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         lba_q    <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         lba_q    <= lba_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      lba_d    = lba_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               grant_d = pick_idx;
               lba_d   = lba_arr[pick_idx];
               wr_d    = drv_wr[pick_idx];
               rd_d    = ~drv_wr[pick_idx];
               state_d = S_REQ;
            end
         end
         // Ack beats a simultaneous withdrawal; a withdrawal leaves rr_ptr alone.
         S_REQ: begin
            if (sd_ack) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = S_XFER;
            end else if (!req[grant_q]) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_XFER: begin
            if (!sd_ack) state_d = S_REL;
         end
         S_REL: begin
            rr_ptr_d = IW'((int'(grant_q) + 1) % int'(NDRIVES));
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy   = (state_q != S_IDLE);
   assign grant  = grant_q;
   assign sd_lba = lba_q;
   assign sd_rd  = rd_q;
   assign sd_wr  = wr_q;

   // Host strobes reach only the granted drive, and nobody while idle.
   always_comb begin
      drv_ack     = '0;
      drv_buff_wr = '0;
      sd_buff_din = '0;
      if (busy) begin
         drv_ack[grant_q]     = sd_ack;
         drv_buff_wr[grant_q] = sd_buff_wr;
         sd_buff_din          = din_arr[grant_q];
      end
   end

endmodule
